// File: rtl/pcm_rx_deframer.sv
// Serial PCM receive deframer: hunts for a sync byte, then emits log-PCM bytes
// per frame while checking the sync byte between frames with a flywheel.
module pcm_rx_deframer #(
  parameter logic [7:0] SYNCWORD = 8'b01110010,
  parameter int         FRAMELEN = 4,
  parameter int         MAXMISS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bitin,
  input  logic       bitvalid,
  output logic [7:0] pcmlog,
  output logic       pcmvalid,
  output logic       locked,
  output logic       syncerr
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAMELEN - 1);
  localparam logic [3:0] MISS_LIM  = 4'(MAXMISS);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] win_q, win_d;
  logic [3:0] fill_q, fill_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic [3:0] miss_q, miss_d;
  logic [7:0] pcm_q, pcm_d;
  logic       pv_q, pv_d;
  logic       se_q, se_d;

  logic [7:0] shifted;
  logic [3:0] miss_inc;

  assign shifted  = {win_q[6:0], bitin};
  assign miss_inc = miss_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      win_q   <= 8'h00;
      fill_q  <= 4'd0;
      bit_q   <= 3'd0;
      byte_q  <= 8'h00;
      miss_q  <= 4'd0;
      pcm_q   <= 8'h00;
      pv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      miss_q  <= miss_d;
      pcm_q   <= pcm_d;
      pv_q    <= pv_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    miss_d  = miss_q;
    pcm_d   = pcm_q;
    pv_d    = 1'b0;
    se_d    = 1'b0;
    if (bitvalid) begin
      win_d = shifted;
      unique case (state_q)
        HUNT: begin
          // fill saturates at 8; a match needs a full fresh window
          if (fill_q != 4'd8) fill_d = fill_q + 4'd1;
          if (fill_q >= 4'd7 && shifted == SYNCWORD) begin
            state_d = DATA;
            bit_d   = 3'd0;
            byte_d  = 8'h00;
            miss_d  = 4'd0;
          end
        end
        DATA: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            pcm_d = shifted;
            pv_d  = 1'b1;
            if (byte_q == LAST_BYTE) begin
              byte_d  = 8'h00;
              state_d = CHECK;
            end else begin
              byte_d = byte_q + 8'd1;
            end
          end
        end
        CHECK: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (shifted == SYNCWORD) begin
              miss_d  = 4'd0;
              state_d = DATA;
            end else begin
              se_d   = 1'b1;
              miss_d = miss_inc;
              if (miss_inc == MISS_LIM) begin
                state_d = HUNT;
                fill_d  = 4'd0;
                miss_d  = 4'd0;
              end else begin
                state_d = DATA;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign pcmlog   = pcm_q;
  assign pcmvalid = pv_q;
  assign syncerr  = se_q;
  assign locked   = (state_q != HUNT);

endmodule
